mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/cpu_pkg.sv | 14 +
 rtl/mem_wait_timer.sv | 32 +++
 rtl/mem_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and default sizing for the memory arbiter slice.
package cpu_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GNT_IF = 2'd1,
      GNT_LS = 2'd2,
      RESP   = 2'd3
   } arb_state_t;

   localparam int DEFAULT_DATA_W  = 32;
   localparam int DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/mem_wait_timer.sv
// Grant wait counter: held at zero while clear is high, counts stalled cycles,
// and flags expiry once the count reaches TIMEOUT-1.
module mem_wait_timer
   import cpu_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic advance,
   output logic expired
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_reg <= '0;
      end else if (clear) begin
         count_reg <= '0;
      end else if (advance && (count_reg != LAST)) begin
         count_reg <= count_reg + CW'(1);
      end
   end

   assign expired = (count_reg == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch, load/store) arbiter for a single memory port with wait timeout.
// Optional macro MEM_ARB_RR_EN switches IDLE arbitration from LS-priority to round-robin.
module mem_arbiter
   import cpu_pkg::*;
#(
   parameter int DATA_W  = DEFAULT_DATA_W,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [DATA_W-1:0] if_addr,
   output logic              if_rvalid,
   output logic              if_err,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [DATA_W-1:0] ls_addr,
   input  logic [DATA_W-1:0] ls_wdata,
   output logic              ls_rvalid,
   output logic              ls_err,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready
);

   arb_state_t state_reg, state_next;
   logic       owner_ls_reg;
   logic       in_gnt, expired, pick_ls, grant, done, abort;

`ifdef MEM_ARB_RR_EN
   // Set when LS won the most recent grant; the other requester wins a tie.
   logic last_ls_reg;
   assign pick_ls = ls_req && (!if_req || !last_ls_reg);
   always_ff @(posedge clk) begin
      if (!rst_n)     last_ls_reg <= 1'b0;
      else if (grant) last_ls_reg <= pick_ls;
   end
`else
   assign pick_ls = ls_req;
`endif

   assign in_gnt = (state_reg == GNT_IF) || (state_reg == GNT_LS);

   mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (!in_gnt),
      .advance (in_gnt && !mem_ready),
      .expired (expired)
   );

   always_comb begin
      state_next = state_reg;
      grant      = 1'b0;
      done       = 1'b0;
      abort      = 1'b0;
      case (state_reg)
         IDLE: begin
            if (pick_ls) begin
               state_next = GNT_LS;
               grant      = 1'b1;
            end else if (if_req) begin
               state_next = GNT_IF;
               grant      = 1'b1;
            end
         end
         GNT_IF, GNT_LS: begin
            // A ready on the final wait cycle still completes the access.
            if (mem_ready) begin
               state_next = RESP;
               done       = 1'b1;
            end else if (expired) begin
               state_next = IDLE;
               abort      = 1'b1;
            end
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         owner_ls_reg <= 1'b0;
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         rdata        <= '0;
         if_rvalid    <= 1'b0;
         ls_rvalid    <= 1'b0;
         if_err       <= 1'b0;
         ls_err       <= 1'b0;
      end else begin
         if_rvalid <= (state_reg == RESP) && !owner_ls_reg;
         ls_rvalid <= (state_reg == RESP) && owner_ls_reg;
         if_err    <= abort && !owner_ls_reg;
         ls_err    <= abort && owner_ls_reg;
         if (grant) begin
            owner_ls_reg <= pick_ls;
            mem_req      <= 1'b1;
            mem_we       <= pick_ls && ls_we;
            mem_addr     <= pick_ls ? ls_addr : if_addr;
            mem_wdata    <= pick_ls ? ls_wdata : '0;
         end else if (done || abort) begin
            mem_req <= 1'b0;
         end
         if (done) rdata <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter: a small memory responder drives mem_ready/mem_rdata,
// expected responses are queued per requester at issue time and popped on each pulse.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic        if_rvalid, if_err;
   logic        ls_req = 1'b0, ls_we = 1'b0;
   logic [31:0] ls_addr = '0, ls_wdata = '0;
   logic        ls_rvalid, ls_err;
   logic [31:0] rdata;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        mem_ready = 1'b0;

   mem_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_rvalid(if_rvalid), .if_err(if_err),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_rvalid(ls_rvalid), .ls_err(ls_err), .rdata(rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   typedef struct { bit err; bit chk_data; logic [31:0] data; } exp_t;
   typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; } gnt_t;

   exp_t        if_q[$], ls_q[$];
   gnt_t        grant_log[$];
   int          errors = 0, checks = 0;
   int          cyc = 0, gnt_cnt = 0, ready_at = 0;
   int          first_req_cyc = 0, last_if_cyc = 0, last_ls_cyc = 0, req_cyc = 0;
   bit          noise = 1'b0;
   int          if_more = 0, ls_more = 0;
   logic [31:0] if_next = '0, ls_next = '0;

   function automatic logic [31:0] rd(input logic [31:0] a);
      return (a == 32'h100) ? 32'hE3A0_0001 : ((a ^ 32'h5A5A_0000) + 32'd7);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic issue_if(input logic [31:0] a, input bit err);
      if_addr = a;
      if_req  = 1'b1;
      if_q.push_back('{err, !err, rd(a)});
   endtask

   task automatic issue_ls(input logic [31:0] a, input logic we, input logic [31:0] wd, input bit err);
      ls_addr  = a;
      ls_we    = we;
      ls_wdata = wd;
      ls_req   = 1'b1;
      ls_q.push_back('{err, !we && !err, rd(a)});
   endtask

   // One clock: sample at the falling edge, play memory, score pulses, then drive.
   task automatic step();
      exp_t e;
      @(negedge clk);
      cyc++;
      if (mem_req) begin
         if (gnt_cnt == 0) begin
            first_req_cyc = cyc;
            grant_log.push_back('{mem_addr, mem_we, mem_wdata});
         end
         mem_ready = (gnt_cnt == ready_at);
         gnt_cnt++;
      end else begin
         gnt_cnt   = 0;
         mem_ready = noise;
      end
      mem_rdata = rd(mem_addr);
      if (if_rvalid || if_err) begin
         last_if_cyc = cyc;
         if (if_q.size() == 0) begin
            chk("if_unexpected_pulse", 32'd1, 32'd0);
         end else begin
            e = if_q.pop_front();
            chk("if_err", {31'd0, if_err}, {31'd0, e.err});
            chk("if_rvalid", {31'd0, if_rvalid}, {31'd0, !e.err});
            if (e.chk_data) chk("if_rdata", rdata, e.data);
         end
         if_req = 1'b0;
         if (if_more > 0) begin
            issue_if(if_next, 1'b0);
            if_next += 32'd4;
            if_more--;
         end
      end
      if (ls_rvalid || ls_err) begin
         last_ls_cyc = cyc;
         if (ls_q.size() == 0) begin
            chk("ls_unexpected_pulse", 32'd1, 32'd0);
         end else begin
            e = ls_q.pop_front();
            chk("ls_err", {31'd0, ls_err}, {31'd0, e.err});
            chk("ls_rvalid", {31'd0, ls_rvalid}, {31'd0, !e.err});
            if (e.chk_data) chk("ls_rdata", rdata, e.data);
         end
         ls_req = 1'b0;
         if (ls_more > 0) begin
            issue_ls(ls_next, 1'b0, 32'd0, 1'b0);
            ls_next += 32'd4;
            ls_more--;
         end
      end
   endtask

   task automatic wait_idle(input int maxc);
      for (int i = 0; i < maxc; i++) begin
         if (if_q.size() == 0 && ls_q.size() == 0 && !if_req && !ls_req) break;
         step();
      end
      chk("drain_pending", if_q.size() + ls_q.size(), 32'd0);
   endtask

   task automatic check_cleared(input string tag);
      chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
      chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
      chk({tag, "_mem_addr"}, mem_addr, 32'd0);
      chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
      chk({tag, "_rdata"}, rdata, 32'd0);
      chk({tag, "_pulses"}, {28'd0, if_rvalid, if_err, ls_rvalid, ls_err}, 32'd0);
   endtask

   logic [31:0] exp_order[4];

   initial begin
      // Reset state
      step();
      step();
      check_cleared("reset");
      rst_n = 1'b1;
      noise = 1'b1;
      step();

      // Single fetch, ready in first grant cycle, latency 3
      ready_at = 0;
      grant_log.delete();
      req_cyc = cyc;
      issue_if(32'h100, 1'b0);
      wait_idle(20);
      chk("if_latency", last_if_cyc - req_cyc, 32'd3);
      chk("if_gnt_count", grant_log.size(), 32'd1);
      if (grant_log.size() >= 1) chk("if_mem_we", {31'd0, grant_log[0].we}, 32'd0);

      // Simultaneous LS write and IF read: LS wins
      grant_log.delete();
      issue_ls(32'h200, 1'b1, 32'h55, 1'b0);
      issue_if(32'h104, 1'b0);
      wait_idle(30);
      chk("tie_gnt_count", grant_log.size(), 32'd2);
      if (grant_log.size() >= 2) begin
         chk("tie_first_addr", grant_log[0].addr, 32'h200);
         chk("tie_first_we", {31'd0, grant_log[0].we}, 32'd1);
         chk("tie_first_wdata", grant_log[0].wdata, 32'h55);
         chk("tie_second_addr", grant_log[1].addr, 32'h104);
         chk("tie_second_we", {31'd0, grant_log[1].we}, 32'd0);
      end

      // LS alone so the most recent grant is LS, then both requesting continuously
      issue_ls(32'h3F0, 1'b0, 32'd0, 1'b0);
      wait_idle(20);
      grant_log.delete();
      if_next = 32'h304;
      ls_next = 32'h404;
      if_more = 1;
      ls_more = 1;
      issue_if(32'h300, 1'b0);
      issue_ls(32'h400, 1'b0, 32'd0, 1'b0);
      wait_idle(60);
`ifdef MEM_ARB_RR_EN
      exp_order = '{32'h300, 32'h400, 32'h304, 32'h404};
`else
      exp_order = '{32'h400, 32'h404, 32'h300, 32'h304};
`endif
      chk("order_count", grant_log.size(), 32'd4);
      for (int i = 0; i < 4 && i < grant_log.size(); i++)
         chk($sformatf("order_%0d", i), grant_log[i].addr, exp_order[i]);

      // LS read timeout
      ready_at = -1;
      issue_ls(32'h500, 1'b0, 32'd0, 1'b1);
      wait_idle(40);
      chk("ls_timeout_latency", last_ls_cyc - first_req_cyc, 32'd16);
      chk("ls_timeout_mem_req", {31'd0, mem_req}, 32'd0);

      // IF read timeout
      issue_if(32'h800, 1'b1);
      wait_idle(40);
      chk("if_timeout_latency", last_if_cyc - first_req_cyc, 32'd16);

      // Ready on the last wait cycle is a success
      ready_at = 15;
      issue_ls(32'h600, 1'b0, 32'd0, 1'b0);
      wait_idle(40);
      chk("ls_late_latency", last_ls_cyc - first_req_cyc, 32'd17);

      // Reset in the middle of a fetch grant
      ready_at = -1;
      issue_if(32'h700, 1'b0);
      for (int i = 0; i < 10 && gnt_cnt == 0; i++) step();
      chk("rst_granted", {31'd0, mem_req}, 32'd1);
      step();
      step();
      rst_n = 1'b0;
      step();
      check_cleared("midrst");
      rst_n  = 1'b1;
      if_req = 1'b0;
      if_q.delete();
      for (int i = 0; i < 20; i++) step();
      chk("midrst_no_req", {31'd0, mem_req}, 32'd0);

      // Normal operation after reset
      ready_at = 2;
      issue_if(32'h704, 1'b0);
      wait_idle(20);
      chk("post_rst_latency", last_if_cyc - first_req_cyc, 32'd4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
